// File: rtl/fault_trend_monitor_if.sv
// Bundle between the per-train fault detectors, the monitor and the self-healing controller.
// master = detector/consumer side, slave = fault_trend_monitor.
interface fault_trend_monitor_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 4
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]       fault_in;
    logic [NUM_CH-1:0]       clr;
    logic [NUM_CH*CNT_W-1:0] count_out;
    logic [NUM_CH-1:0]       predict_flag;
    logic                    predict_any;
    logic                    evt_valid;
    logic [CH_W-1:0]         evt_ch;
    logic                    evt_ready;

    modport master (
        output fault_in, clr, evt_ready,
        input  count_out, predict_flag, predict_any, evt_valid, evt_ch
    );

    modport slave (
        input  fault_in, clr, evt_ready,
        output count_out, predict_flag, predict_any, evt_valid, evt_ch
    );
endinterface

// File: rtl/fault_trend_monitor.sv
// Per-channel fault edge counter with sticky threshold prediction and a valid/ready event port.
// Optional leaky decay of WATCH channels is compiled in with `define FTM_DECAY_EN.
module fault_trend_monitor #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 4,
    parameter int THRESH       = 3,
    parameter int DECAY_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    fault_trend_monitor_if.slave bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

    typedef enum logic [1:0] {IDLE, WATCH, PREDICT} ch_state_e;

    logic [NUM_CH-1:0] prev_q;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] flag;
    logic [NUM_CH-1:0] pop;
    logic              decay_tick;
    logic              evt_valid_q;
    logic [CH_W-1:0]   evt_ch_q;
    logic [CH_W-1:0]   evt_ch_d;
    logic              predict_any_q;
    logic              load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_q <= '0;
        else     prev_q <= bus.fault_in;
    end

    assign rise = bus.fault_in & ~prev_q;

`ifdef FTM_DECAY_EN
    localparam int TMR_W = (DECAY_CYCLES > 2) ? $clog2(DECAY_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DECAY_CYCLES - 1);

    logic [TMR_W-1:0] tmr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   tmr_q <= '0;
        else if (tmr_q == TMR_LAST) tmr_q <= '0;
        else                       tmr_q <= tmr_q + 1'b1;
    end

    assign decay_tick = (tmr_q == TMR_LAST);
`else
    // No timer: the decay period has no effect, the tick is constant low.
    assign decay_tick = (DECAY_CYCLES < 0);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            ch_state_e        state_q;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_inc;
            logic             flag_q;
            logic             pend_q;

            assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

            // clr beats an edge in the same cycle; an edge beats a decay tick.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    flag_q  <= 1'b0;
                    pend_q  <= 1'b0;
                end else if (bus.clr[gi]) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    flag_q  <= 1'b0;
                    pend_q  <= 1'b0;
                end else begin
                    if (pop[gi]) pend_q <= 1'b0;
                    if (rise[gi]) begin
                        cnt_q <= cnt_inc;
                        if (state_q != PREDICT) begin
                            if (cnt_inc >= THRESH_C) begin
                                state_q <= PREDICT;
                                flag_q  <= 1'b1;
                                pend_q  <= 1'b1;
                            end else begin
                                state_q <= WATCH;
                            end
                        end
                    end else if (decay_tick && state_q == WATCH) begin
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) state_q <= IDLE;
                    end
                end
            end

            assign bus.count_out[gi*CNT_W +: CNT_W] = cnt_q;
            assign flag[gi]    = flag_q;
            assign pending[gi] = pend_q;
        end
    endgenerate

    always_comb begin
        evt_ch_d = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending[i]) evt_ch_d = CH_W'(i);
        end
    end

    // Output stage reloads when empty or when its current event is being taken.
    assign load = ~evt_valid_q | bus.evt_ready;
    assign pop  = load ? (pending & (~pending + 1'b1)) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_valid_q   <= 1'b0;
            evt_ch_q      <= '0;
            predict_any_q <= 1'b0;
        end else begin
            predict_any_q <= |flag;
            if (load) begin
                evt_valid_q <= |pending;
                if (|pending) evt_ch_q <= evt_ch_d;
            end
        end
    end

    assign bus.predict_flag = flag;
    assign bus.predict_any  = predict_any_q;
    assign bus.evt_valid    = evt_valid_q;
    assign bus.evt_ch       = evt_ch_q;
endmodule

// File: tb/tb_fault_trend_monitor.sv
// Directed bench for fault_trend_monitor; events are checked against a queue of expected channels.
module tb_fault_trend_monitor;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 4;
    localparam int THRESH = 3;
    localparam int DECAY  = 8;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_q[$];

    always #5 clk = ~clk;

    fault_trend_monitor_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    fault_trend_monitor #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .THRESH(THRESH), .DECAY_CYCLES(DECAY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt(input int ch);
        return 32'(bus.count_out[ch*CNT_W +: CNT_W]);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input logic [NUM_CH-1:0] mask);
        bus.fault_in = bus.fault_in | mask;
        cyc();
        bus.fault_in = bus.fault_in & ~mask;
        cyc();
    endtask

    // Transfers are observed mid-cycle, before the edge that completes them.
    always @(negedge clk) begin
        if (!rst && bus.evt_valid && bus.evt_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $error("FAIL evt_unexpected: observed ch %0d expected no event", bus.evt_ch);
            end else begin
                check("evt_ch", 32'(bus.evt_ch), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_cnt;
        int t1;
        int t0;
        bus.fault_in  = '0;
        bus.clr       = '0;
        bus.evt_ready = 1'b1;

        // Reset state
        #3;
        check("rst_count",   bus.count_out, 0);
        check("rst_flag",    bus.predict_flag, 0);
        check("rst_any",     bus.predict_any, 0);
        check("rst_valid",   bus.evt_valid, 0);
        check("rst_evt_ch",  bus.evt_ch, 0);
        cyc();
        rst = 1'b0;
        cyc();

        // Ch0 reaches threshold after three edges
        for (int k = 1; k <= 3; k++) begin
            if (k == THRESH) exp_q.push_back(0);
            pulse(4'b0001);
            check("t1_count0", cnt(0), k);
            check("t1_flag0", bus.predict_flag[0], (k >= THRESH) ? 1 : 0);
        end
        check("t1_any", bus.predict_any, 1);
        check("t1_valid", bus.evt_valid, 1);
        check("t1_evt_ch", bus.evt_ch, 0);
        cyc();
        check("t1_valid_drop", bus.evt_valid, 0);

        // Ch1 held high counts once, then saturates
        bus.fault_in[1] = 1'b1;
        repeat (20) cyc();
        check("t2_hold_count", cnt(1), 1);
        check("t2_hold_flag", bus.predict_flag[1], 0);
        bus.fault_in[1] = 1'b0;
        cyc();
        exp_cnt = 1;
        for (int k = 0; k < 16; k++) begin
            if (exp_cnt + 1 == THRESH) exp_q.push_back(1);
            pulse(4'b0010);
            exp_cnt = (exp_cnt + 1 > CMAX) ? CMAX : exp_cnt + 1;
            check("t2_count1", cnt(1), exp_cnt);
        end
        check("t2_sat", cnt(1), CMAX);
        check("t2_flag1", bus.predict_flag[1], 1);
        cyc();

        // Ch2 and ch3 predict together while the consumer stalls
        bus.evt_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (k == THRESH) begin
                exp_q.push_back(2);
                exp_q.push_back(3);
            end
            pulse(4'b1100);
        end
        check("t3_flags", bus.predict_flag[3:2], 2'b11);
        for (int k = 0; k < 5; k++) begin
            check("t3_stall_valid", bus.evt_valid, 1);
            check("t3_stall_ch", bus.evt_ch, 2);
            cyc();
        end
        bus.evt_ready = 1'b1;
        cyc();
        check("t3_second_valid", bus.evt_valid, 1);
        check("t3_second_ch", bus.evt_ch, 3);
        cyc();
        check("t3_drain", bus.evt_valid, 0);

        // clr on ch0 in PREDICT together with an edge
        check("t4_pre_flag0", bus.predict_flag[0], 1);
        bus.fault_in[0] = 1'b1;
        bus.clr[0]      = 1'b1;
        cyc();
        check("t4_count0", cnt(0), 0);
        check("t4_flag0", bus.predict_flag[0], 0);
        bus.fault_in[0] = 1'b0;
        bus.clr[0]      = 1'b0;
        cyc();
        check("t4_no_evt", bus.evt_valid, 0);
        cyc();
        check("t4_no_evt2", bus.evt_valid, 0);

        // Async reset while an event is stalled
        bus.evt_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (k == THRESH) exp_q.push_back(0);
            pulse(4'b0001);
        end
        check("t5_pre_valid", bus.evt_valid, 1);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_count", bus.count_out, 0);
        check("t5_rst_flag", bus.predict_flag, 0);
        check("t5_rst_any", bus.predict_any, 0);
        check("t5_rst_valid", bus.evt_valid, 0);
        check("t5_rst_ch", bus.evt_ch, 0);
        exp_q.delete();
        cyc();
        rst = 1'b0;
        bus.evt_ready = 1'b1;
        cyc();
        check("t5_post_valid", bus.evt_valid, 0);
        check("t5_post_count0", cnt(0), 0);

`ifdef FTM_DECAY_EN
        // Decay: re-align the timer with a reset, then watch ch1 age out
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        pulse(4'b0110);
        pulse(4'b0110);
        exp_q.push_back(2);
        pulse(4'b0100);
        check("t6_count1", cnt(1), 2);
        t1 = -1;
        t0 = -1;
        for (int c = 7; c < 40; c++) begin
            cyc();
            if (t1 < 0 && cnt(1) == 1) t1 = c;
            if (t0 < 0 && cnt(1) == 0) t0 = c;
        end
        check("t6_first_tick", t1, 8);
        check("t6_second_tick", t0, 16);
        check("t6_predict_hold", cnt(2), 3);
        check("t6_predict_flag", bus.predict_flag[2], 1);
`else
        t1 = 0;
        t0 = 0;
        repeat (20) cyc();
        check("t6_no_decay_ch1", cnt(1) + 32'(t1 + t0), 0);
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
